// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU status bit positions, exception
// cause codes and the exception unit's state encoding.
package mips_pkg;

  localparam int ST_ZERO  = 7;
  localparam int ST_OVF   = 6;
  localparam int ST_CARRY = 5;
  localparam int ST_NEG   = 4;
  localparam int ST_ODD   = 3;
  localparam int ST_DZ    = 2;

  // Bits [1:0] of the ALU status carry nothing and are never committed.
  localparam logic [7:0] FLAG_MASK = 8'hFC;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_DZ   = 2'd2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

endpackage

// File: rtl/alu_exception_unit.sv
// Registered execute back end: one-cycle result forwarding, committed flags,
// trap detection with EPC/cause capture, flush and redirect to the vector.
//
// state   | meaning
// RUN     | normal execution; a trap captures EPC/cause and redirects
// FLUSH   | younger instructions killed for FLUSH_CYCLES cycles
// HANDLER | handler code runs; traps only set double_fault; eret returns
module alu_exception_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             trap_ovf_en,
  input  logic [31:0]      alu_result,
  input  logic [7:0]       alu_status,
  input  logic             eret,
  output logic             wb_valid,
  output logic [31:0]      wb_result,
  output logic [7:0]       flags_q,
  output logic             flush,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [1:0]       cause,
  output logic             in_handler,
  output logic             double_fault,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_t state;
  logic [3:0] flush_cnt;
  logic       dz;
  logic       trap;

  assign dz   = alu_status[ST_DZ];
  assign trap = ex_valid & ((alu_status[ST_OVF] & trap_ovf_en) | dz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      flush_cnt    <= '0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      flags_q      <= '0;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      epc          <= '0;
      cause        <= CAUSE_NONE;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
      exc_count    <= '0;
    end else begin
      redirect <= 1'b0;
      case (state)
        RUN: begin
          if (trap) begin
            wb_valid    <= 1'b0;
            epc         <= ex_pc;
            cause       <= dz ? CAUSE_DZ : CAUSE_OVF;
            if (exc_count != '1) exc_count <= exc_count + 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= EXC_VECTOR;
            flush       <= 1'b1;
            flush_cnt   <= FLUSH_LOAD;
            state       <= FLUSH;
          end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
              wb_result <= alu_result;
              flags_q   <= alu_status & FLAG_MASK;
            end
          end
        end
        FLUSH: begin
          wb_valid <= 1'b0;
          if (flush_cnt == 4'd0) begin
            flush      <= 1'b0;
            in_handler <= 1'b1;
            state      <= HANDLER;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        HANDLER: begin
          if (trap) double_fault <= 1'b1;
          // eret wins over any same-cycle result, which is dropped
          if (eret) begin
            wb_valid    <= 1'b0;
            redirect    <= 1'b1;
            redirect_pc <= epc;
            cause       <= CAUSE_NONE;
            in_handler  <= 1'b0;
            state       <= RUN;
          end else if (trap) begin
            wb_valid <= 1'b0;
          end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
              wb_result <= alu_result;
              flags_q   <= alu_status & FLAG_MASK;
            end
          end
        end
        default: begin
          in_handler <= 1'b0;
          flush      <= 1'b0;
          state      <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exception_unit.sv
// Scoreboard bench for alu_exception_unit: directed test-plan cases followed
// by random traffic, checked against a behavioural model of the exception flow.
module tb_alu_exception_unit;

  localparam int CW = 4;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'h0000_0080;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic          trap_ovf_en;
  logic [31:0]   alu_result;
  logic [7:0]    alu_status;
  logic          eret;
  logic          wb_valid;
  logic [31:0]   wb_result;
  logic [7:0]    flags_q;
  logic          flush;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   epc;
  logic [1:0]    cause;
  logic          in_handler;
  logic          double_fault;
  logic [CW-1:0] exc_count;

  always #5 clk = ~clk;

  alu_exception_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .trap_ovf_en(trap_ovf_en), .alu_result(alu_result), .alu_status(alu_status),
    .eret(eret), .wb_valid(wb_valid), .wb_result(wb_result), .flags_q(flags_q),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc),
    .cause(cause), .in_handler(in_handler), .double_fault(double_fault),
    .exc_count(exc_count)
  );

  typedef struct {
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [7:0]  flags;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler;
    logic        double_fault;
    int          exc_count;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   mode;        // 0 running, 1 flushing, 2 in handler
  int   flush_left;  // flush cycles still to be shown
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("wb_valid", 32'(wb_valid), 32'(e.wb_valid));
    if (e.wb_valid) chk("wb_result", wb_result, e.wb_result);
    chk("flags_q", 32'(flags_q), 32'(e.flags));
    chk("flush", 32'(flush), 32'(e.flush));
    chk("redirect", 32'(redirect), 32'(e.redirect));
    if (e.redirect) chk("redirect_pc", redirect_pc, e.redirect_pc);
    chk("epc", epc, e.epc);
    chk("cause", 32'(cause), 32'(e.cause));
    chk("in_handler", 32'(in_handler), 32'(e.in_handler));
    chk("double_fault", 32'(double_fault), 32'(e.double_fault));
    chk("exc_count", 32'(exc_count), 32'(e.exc_count));
  endtask

  task automatic model_reset();
    m = '{default: '0};
    mode = 0;
    flush_left = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] pc, input bit oe,
                            input logic [31:0] res, input logic [7:0] st, input bit er);
    bit trap;
    trap = v && ((st[6] && oe) || st[2]);
    m.redirect = 1'b0;
    if (mode == 0) begin
      if (trap) begin
        m.wb_valid = 1'b0;
        m.epc = pc;
        m.cause = st[2] ? 2'd2 : 2'd1;
        m.exc_count = (m.exc_count < CNT_MAX) ? m.exc_count + 1 : CNT_MAX;
        m.redirect = 1'b1;
        m.redirect_pc = VEC;
        m.flush = 1'b1;
        flush_left = FC;
        mode = 1;
      end else begin
        m.wb_valid = v;
        if (v) begin m.wb_result = res; m.flags = {st[7:2], 2'b00}; end
      end
    end else if (mode == 1) begin
      m.wb_valid = 1'b0;
      flush_left--;
      if (flush_left == 0) begin
        m.flush = 1'b0;
        m.in_handler = 1'b1;
        mode = 2;
      end
    end else begin
      if (trap) m.double_fault = 1'b1;
      if (er) begin
        m.wb_valid = 1'b0;
        m.redirect = 1'b1;
        m.redirect_pc = m.epc;
        m.cause = 2'd0;
        m.in_handler = 1'b0;
        mode = 0;
      end else if (trap) begin
        m.wb_valid = 1'b0;
      end else begin
        m.wb_valid = v;
        if (v) begin m.wb_result = res; m.flags = {st[7:2], 2'b00}; end
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input bit oe,
                      input logic [31:0] res, input logic [7:0] st, input bit er);
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = v; ex_pc = pc; trap_ovf_en = oe;
    alu_result = res; alu_status = st; eret = er;
    model_step(v, pc, oe, res, st, er);
    q.push_back(m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ex_valid = 1'b0; eret = 1'b0; alu_status = 8'h00; trap_ovf_en = 1'b0;
    #1;
    model_reset();
    compare_all(m);
    chk("rst_wb_result", wb_result, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    q.push_back(m);
  endtask

  // Monitor: every cycle the DUT presents a registered output bundle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) compare_all(q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_pc = '0; trap_ovf_en = 1'b0;
    alu_result = '0; alu_status = '0; eret = 1'b0;
    model_reset();
    do_reset();

    step(1'b1, 32'h0040_0000, 1'b0, 32'h0000_0005, 8'b0000_1000, 1'b0);
    step(1'b1, 32'h0040_0010, 1'b1, 32'hDEAD_BEEF, 8'h40, 1'b0);
    idle(3);
    step(1'b1, 32'h0000_0084, 1'b0, 32'h1234_5678, 8'h04, 1'b0);
    step(1'b1, 32'h0000_0088, 1'b0, 32'h0000_0009, 8'hA8, 1'b0);
    step(1'b1, 32'h0000_008C, 1'b0, 32'h0000_0077, 8'h00, 1'b1);
    step(1'b1, 32'h0040_0014, 1'b0, 32'h0000_0011, 8'h40, 1'b0);
    step(1'b1, 32'h0040_0020, 1'b1, 32'h0000_0022, 8'h44, 1'b0);
    idle(3);
    step(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1);
    step(1'b1, 32'h0040_0030, 1'b1, 32'h0000_0033, 8'h40, 1'b0);
    step(1'b1, 32'h0040_0034, 1'b0, 32'h0000_0044, 8'h00, 1'b1);
    do_reset();
    step(1'b1, 32'h0040_0100, 1'b0, 32'hCAFE_0001, 8'h93, 1'b0);
    idle(1);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] st;
      bit v, oe, er;
      st = 8'($urandom);
      st[2] = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 3) != 0);
      oe = ($urandom_range(0, 4) == 0);
      er = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(v, $urandom, oe, $urandom, st, er);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exception_unit.md
# alu_exception_unit

Registered back end of the execute stage. It samples the ALU result and 8-bit ALU status each valid cycle, forwards the result to writeback with one cycle of latency, and holds a flag register for the branch logic. It also detects trapping conditions (signed overflow on trapping ops, divide by zero), captures EPC/cause, and drives a flush and PC redirect to the exception vector. It sits between the ALU and the EX/WB register and the fetch PC mux.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0080, redirect target on exception
- FLUSH_CYCLES, 2, cycles of flush asserted after detection (1..15)
- CNT_W, 8, width of saturating exception counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  ALU output valid this cycle
- ex_pc  in  32  PC of the instruction in execute
- trap_ovf_en  in  1  instruction traps on signed overflow (add/sub signed)
- alu_result  in  32  ALU result
- alu_status  in  8  [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd, [2] div-by-zero, [1:0] ignored
- eret  in  1  return-from-exception, valid in HANDLER only
- wb_valid  out  1  registered result valid
- wb_result  out  32  registered ALU result
- flags_q  out  8  last committed status; bits [1:0] always 0
- flush  out  1  kill younger instructions
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  EXC_VECTOR on exception, epc on eret
- epc  out  32  PC of faulting instruction
- cause  out  2  1 = overflow, 2 = div-by-zero, 0 = none
- in_handler  out  1  state is HANDLER
- double_fault  out  1  sticky; trap seen while in HANDLER
- exc_count  out  CNT_W  saturating count of taken exceptions

## Operation
- Trap condition `trap` = ex_valid & ((alu_status[6] & trap_ovf_en) | alu_status[2]). If both conditions hold, div-by-zero takes priority (cause = 2).
- FSM states: RUN, FLUSH, HANDLER.
- RUN, no trap:
  - ex_valid=1: wb_valid<=1, wb_result<=alu_result, flags_q<={alu_status[7:2],2'b00}.
  - ex_valid=0: wb_valid<=0. flags_q holds.
- RUN, trap:
  - wb_valid<=0; flags_q holds.
  - epc<=ex_pc; cause set; exc_count increments (saturates at all-ones).
  - redirect<=1 with redirect_pc<=EXC_VECTOR; flush<=1; flush counter loads FLUSH_CYCLES-1; go to FLUSH.
- FLUSH:
  - ex_valid ignored; wb_valid=0; flush=1.
  - Counter decrements; at 0, flush<=0 and go to HANDLER.
  - eret is ignored.
- HANDLER:
  - Handler code executes normally: results and flags update as in RUN.
  - A trap sets double_fault and is otherwise suppressed: no EPC/cause change, no redirect. Result is not written (wb_valid<=0).
  - eret: redirect<=1, redirect_pc<=epc, cause<=0; go to RUN. Same-cycle ex_valid is dropped (wb_valid<=0). A same-cycle trap still sets double_fault.
- eret in RUN or FLUSH: no effect.
- double_fault is cleared only by reset.

## Timing
- Result latency: 1 cycle (input at edge N -> wb_* valid after edge N).
- Trap sampled at edge N:
  - redirect high for exactly the cycle after edge N.
  - flush high for FLUSH_CYCLES cycles starting that same cycle.
  - in_handler rises after edge N+FLUSH_CYCLES.
- eret sampled at edge M: redirect high for the one cycle after M; in_handler low from the same cycle.
- Reset (async, any state including mid-FLUSH):
  - state=RUN; epc=0; cause=0; exc_count=0; double_fault=0.
  - wb_valid=0, wb_result=0, flags_q=0.
  - flush=0, redirect=0, redirect_pc=0, in_handler=0.

## Structure
- Shared package `mips_pkg`:
  - ALU status bit indices (ST_ZERO=7, ST_OVF=6, ST_CARRY=5, ST_NEG=4, ST_ODD=3, ST_DZ=2).
  - Cause codes (CAUSE_NONE/OVF/DZ).
  - FSM state encoding (RUN/FLUSH/HANDLER).
- No sub-module; the flush counter and the exception counter stay inline.

## Test plan
- Pass-through: ex_valid=1, alu_result=32'h0000_0005, status=8'b0000_1000 -> next cycle wb_valid=1, wb_result=5, flags_q=8'h08, redirect=0.
- Overflow trap: trap_ovf_en=1, status[6]=1, ex_pc=32'h0040_0010 -> redirect 1 cycle to 32'h80, flush 2 cycles, epc=32'h0040_0010, cause=1, exc_count=1, wb_valid=0, then in_handler=1.
- Masked overflow: status[6]=1, trap_ovf_en=0 -> normal writeback; flags_q[6]=1; no redirect.
- Div-by-zero plus overflow on the same instruction -> cause=2, a single redirect.
- In HANDLER: div-by-zero -> double_fault=1, epc unchanged. Then eret -> redirect_pc=epc for 1 cycle, state RUN, cause=0.
- Reset asserted mid-FLUSH -> all outputs zero immediately. After release, a normal instruction writes back in 1 cycle.
